// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step, reset PC and FSM state type for the fetch stage
package fetch_pkg;
  localparam int PC_W = 9;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  typedef enum logic [1:0] {S_BOOT, S_SEQ, S_SLOT} state_e;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: next fetch PC from sequential step, redirect target or pending delay-slot target
module fetch_next_pc #(
  parameter int PC_W = fetch_pkg::PC_W
) (
  input  logic [PC_W-1:0]  pc_i,
  input  fetch_pkg::state_e state_i,
  input  logic             redirect_i,
  input  logic             accept_i,
  input  logic             buf_valid_i,
  input  logic [PC_W-1:0]  target_i,
  input  logic [PC_W-1:0]  pend_tgt_i,
  output logic [PC_W-1:0]  pc_d_o
);
  import fetch_pkg::*;
  logic seq_redirect;
  assign seq_redirect = (state_i == S_SEQ) && redirect_i;
  // A redirect jumps now unless the delay slot is still to be fetched
  assign pc_d_o = (state_i == S_SLOT) ? (accept_i ? pend_tgt_i : pc_i) :
                  (seq_redirect && (buf_valid_i || accept_i)) ? target_i :
                  accept_i ? pc_i + PC_W'(PC_STEP) : pc_i;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, imem handshake, one-entry fetch buffer and single-delay-slot redirects
module instruction_fetch_unit #(
  parameter int PC_W = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_load_enable,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump_taken,
  input  logic [PC_W-1:0]    jump_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               fetch_valid
);
  import fetch_pkg::*;
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pend_q, pend_d, pco_q, pco_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic bv_q, bv_d;
  logic redirect, accept, consume, capture;
  logic [PC_W-1:0] tgt_raw, target;
  assign redirect = (state_q == S_SEQ) && (jump_taken || branch_taken);
  assign tgt_raw = jump_taken ? jump_target : branch_target;
  assign target = {tgt_raw[PC_W-1:2], 2'b00};
  assign imem_req = (state_q != S_BOOT) && (!bv_q || pc_load_enable);
  assign accept = imem_req && imem_ready;
  assign consume = bv_q && pc_load_enable;
  // With the delay slot already buffered, a same-cycle fetch is wrong-path
  assign capture = accept && !(redirect && bv_q);
  fetch_next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc_i        (pc_q),
    .state_i     (state_q),
    .redirect_i  (redirect),
    .accept_i    (accept),
    .buf_valid_i (bv_q),
    .target_i    (target),
    .pend_tgt_i  (pend_q),
    .pc_d_o      (pc_d)
  );
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    case (state_q)
      S_BOOT: state_d = S_SEQ;
      S_SEQ: if (redirect && !bv_q && !accept) begin
        state_d = S_SLOT;
        pend_d = target;
      end
      S_SLOT: state_d = accept ? S_SEQ : S_SLOT;
      default: state_d = S_BOOT;
    endcase
  end
  always_comb begin
    instr_d = capture ? imem_rdata : instr_q;
    pco_d = capture ? pc_q : pco_q;
    bv_d = capture ? 1'b1 : consume ? 1'b0 : bv_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q <= RESET_PC;
      pend_q <= '0;
      instr_q <= '0;
      pco_q <= '0;
      bv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
      instr_q <= instr_d;
      pco_q <= pco_d;
      bv_q <= bv_d;
    end
  end
  assign imem_addr = pc_q;
  assign instr_out = instr_q;
  assign pc_out = pco_q;
  assign fetch_valid = bv_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed sequence with a PC scoreboard checked whenever IF/ID loads
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pc_load_enable = 1'b1;
  logic branch_taken = 1'b0;
  logic [8:0] branch_target = '0;
  logic jump_taken = 1'b0;
  logic [8:0] jump_target = '0;
  logic imem_req;
  logic [8:0] imem_addr;
  logic [31:0] imem_rdata;
  logic imem_ready = 1'b1;
  logic [31:0] instr_out;
  logic [8:0] pc_out;
  logic fetch_valid;
  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [8:0] a);
    return {8'hC0, 15'd0, a};
  endfunction

  assign imem_rdata = word(imem_addr);

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .pc_load_enable (pc_load_enable),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump_taken     (jump_taken),
    .jump_target    (jump_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .fetch_valid    (fetch_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on every IF/ID load, then advance one clock
  task automatic cyc();
    logic [8:0] e;
    if (fetch_valid && pc_load_enable) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL extra_issue: got pc %h expected no instruction", pc_out);
      end else begin
        e = exp_q.pop_front();
        chk("issue_pc", 32'(pc_out), 32'(e));
        chk("issue_instr", instr_out, word(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    #1;
    chk("rst_valid", 32'(fetch_valid), 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_pc_out", 32'(pc_out), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("boot_req", 32'(imem_req), 0);
    chk("boot_valid", 32'(fetch_valid), 0);
    cyc();
    #1;
    chk("first_req", 32'(imem_req), 1);
    chk("first_addr", 32'(imem_addr), 0);
    chk("first_valid", 32'(fetch_valid), 0);
    exp_q.push_back(9'h000);
    cyc();
    #1;
    chk("valid_rise", 32'(fetch_valid), 1);
    chk("seq_addr4", 32'(imem_addr), 4);
    exp_q.push_back(9'h004);
    cyc();
    imem_ready = 1'b0;
    #1;
    chk("wait_addr0", 32'(imem_addr), 8);
    exp_q.push_back(9'h008);
    cyc();
    #1;
    chk("wait_valid_drop", 32'(fetch_valid), 0);
    chk("wait_addr1", 32'(imem_addr), 8);
    chk("wait_req", 32'(imem_req), 1);
    cyc();
    #1;
    chk("wait_addr2", 32'(imem_addr), 8);
    cyc();
    imem_ready = 1'b1;
    #1;
    chk("wait_addr3", 32'(imem_addr), 8);
    cyc();
    #1;
    exp_q.push_back(9'h00C);
    cyc();
    pc_load_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_req", 32'(imem_req), 0);
      chk("stall_pc_out", 32'(pc_out), 32'h00C);
      chk("stall_instr", instr_out, word(9'h00C));
      chk("stall_addr", 32'(imem_addr), 32'h010);
      cyc();
    end
    pc_load_enable = 1'b1;
    exp_q.push_back(9'h010);
    #1;
    chk("resume_req", 32'(imem_req), 1);
    chk("resume_addr", 32'(imem_addr), 32'h010);
    cyc();
    exp_q.push_back(9'h014);
    #1;
    cyc();
    branch_taken = 1'b1;
    branch_target = 9'h043;
    exp_q.push_back(9'h040);
    #1;
    chk("br_addr", 32'(imem_addr), 32'h018);
    chk("br_slot_pc", 32'(pc_out), 32'h014);
    cyc();
    branch_taken = 1'b0;
    #1;
    chk("br_drop_valid", 32'(fetch_valid), 0);
    chk("br_target_addr", 32'(imem_addr), 32'h040);
    cyc();
    imem_ready = 1'b0;
    exp_q.push_back(9'h044);
    #1;
    chk("br_tgt_valid", 32'(fetch_valid), 1);
    cyc();
    jump_taken = 1'b1;
    jump_target = 9'h080;
    branch_taken = 1'b1;
    branch_target = 9'h040;
    #1;
    chk("jmp_empty", 32'(fetch_valid), 0);
    chk("jmp_addr", 32'(imem_addr), 32'h044);
    cyc();
    jump_taken = 1'b0;
    branch_target = 9'h100;
    imem_ready = 1'b1;
    #1;
    chk("slot_addr", 32'(imem_addr), 32'h044);
    chk("slot_req", 32'(imem_req), 1);
    exp_q.push_back(9'h080);
    cyc();
    branch_taken = 1'b0;
    #1;
    chk("jmp_tgt_addr", 32'(imem_addr), 32'h080);
    cyc();
    jump_taken = 1'b1;
    jump_target = 9'h1FC;
    exp_q.push_back(9'h1FC);
    #1;
    chk("jmp2_addr", 32'(imem_addr), 32'h084);
    cyc();
    jump_taken = 1'b0;
    #1;
    chk("wrap_pre_valid", 32'(fetch_valid), 0);
    chk("wrap_pre_addr", 32'(imem_addr), 32'h1FC);
    cyc();
    imem_ready = 1'b0;
    #1;
    chk("wrap_addr", 32'(imem_addr), 0);
    cyc();
    reset = 1'b1;
    #1;
    chk("midwait_req", 32'(imem_req), 1);
    chk("midwait_valid", 32'(fetch_valid), 0);
    cyc();
    reset = 1'b0;
    imem_ready = 1'b1;
    #1;
    chk("post_rst_valid", 32'(fetch_valid), 0);
    chk("post_rst_req", 32'(imem_req), 0);
    chk("post_rst_addr", 32'(imem_addr), 0);
    chk("post_rst_instr", instr_out, 0);
    chk("post_rst_pc_out", 32'(pc_out), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);
    cyc();
    #1;
    chk("refetch_req", 32'(imem_req), 1);
    chk("refetch_addr", 32'(imem_addr), 0);
    exp_q.push_back(9'h000);
    cyc();
    #1;
    chk("refetch_valid", 32'(fetch_valid), 1);
    cyc();
    pc_load_enable = 1'b0;
    #1;
    chk("final_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
